mem_block_fetch: RTL and testbench
==================================

# mem_block_fetch

Read-side sequencer between the 64-bit word memory (64K × 64, registered read, one-cycle latency) and the 512-bit crypto core. On a start command it reads 8 consecutive 64-bit words per block for one or more consecutive blocks. It packs each group of 8 words into a 512-bit message block and hands that block to the core over a valid/ready handshake. It owns the memory read port only while fetching; write-side loading is handled elsewhere.

## Interface
Parameters:
- WORDS_PER_BLK, 8, 64-bit words per block; fixed at 8 (512-bit block).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset; one clock; asserting it clears all state immediately.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  16  word address of the first word of block 0; captured on accepted start.
- num_blocks  in  8  number of blocks to fetch; captured on accepted start.
- busy  out  1  high from the accepted start until the end of the command.
- done  out  1  one-cycle pulse when the command finishes.
- mem_en  out  1  high while this block drives the memory port (READ states only).
- mem_rd_wr  out  1  always 0 (read); drives the memory rd_wr input when mem_en is high.
- mem_address  out  16  word address to the memory.
- mem_rdata  in  64  memory out_data; valid one cycle after the address was issued.
- blk_data  out  512  assembled block; word k sits at bits [511-64k : 448-64k], so word 0 occupies the MSBs.
- blk_valid  out  1  block available.
- blk_ready  in  1  consumer accepts the block.

## Operation
- States: IDLE, READ, CAP, HOLD.
- IDLE:
  - start=1 with num_blocks≠0: capture base_addr into the address counter and num_blocks into the remaining counter; set busy; go to READ with word_cnt=0.
  - start=1 with num_blocks=0: pulse done for one cycle; busy stays 0; no memory access.
- READ:
  - mem_en=1, mem_address=addr_cnt.
  - Each cycle: addr_cnt+1, word_cnt+1.
  - From the second READ cycle on, capture mem_rdata into slot word_cnt-1.
  - When word_cnt=7 is issued, go to CAP.
- CAP:
  - mem_en=0; capture mem_rdata into slot 7.
  - Set blk_valid; go to HOLD.
- HOLD:
  - blk_valid=1; blk_data is stable.
  - On blk_valid & blk_ready: clear blk_valid and decrement the remaining counter.
    - Remaining counter now nonzero: go to READ with word_cnt=0. addr_cnt continues, so block b starts at base_addr+8b.
    - Otherwise: pulse done, clear busy, go to IDLE.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 → 0x0000. There is no error on wrap.
- start is ignored while busy, including in HOLD.
- blk_data keeps the last block after done, until the next command overwrites it slot by slot.

## Timing
- Reset values: busy 0, done 0, mem_en 0, mem_rd_wr 0, mem_address 0x0000, blk_valid 0, blk_data all-zero; state IDLE; counters 0.
- Start accepted at edge E0: mem_address=base_addr in the cycle after E0.
- blk_valid rises after edge E0+9. This is 8 READ cycles plus CAP.
- Subsequent blocks: blk_valid rises 9 edges after the handshake edge.
- Back-to-back blocks therefore occupy 10 cycles minimum with blk_ready held high.
- done asserts in the cycle after the final handshake edge, for exactly 1 cycle; busy falls on the same edge.
- blk_ready while blk_valid=0 is ignored.
- Reset mid-command: all outputs return to reset values asynchronously. After release the block is in IDLE and no partial block is presented. Memory contents are unaffected.
- mem_en low outside READ lets the writer share the port. Arbitration is external and is not this block's responsibility.

## Test plan
- Single block: preload mem[0x0100..0x0107]=0x1111…1 through 0x8888…8; start with base_addr=0x0100, num_blocks=1, blk_ready=1 → mem_address steps 0x0100..0x0107 on consecutive cycles; blk_valid after edge E0+9; blk_data=0x1111…1_2222…2_…_8888…8 (word 0 in the MSBs); done pulses 1 cycle; busy returns to 0.
- Multi-block with backpressure: num_blocks=3, base_addr=0x0200, blk_ready held low 5 cycles per block → blk_data holds steady while waiting; the 3 blocks match words 0x0200–0x0217; a single done pulse after the third handshake.
- Wrap-around: base_addr=0xFFFC, num_blocks=1 → addresses 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003; data assembled in that order.
- Zero blocks / ignored start: num_blocks=0 → done pulse the next cycle, mem_en never high. A start pulsed during HOLD of a 2-block command → no effect; the second block comes from base_addr+8.
- Async reset mid-fetch: drop rst during the 4th READ cycle, between edges → busy, mem_en and blk_valid go to 0 immediately. After release, a new start with num_blocks=1 fetches a correct block.

Source files
------------

// File: rtl/mem_block_fetch_if.sv
// Memory read port plus 512-bit block stream between the fetcher and its neighbours.
// master = the fetcher; slave = memory/consumer side.
interface mem_block_fetch_if;
    logic         mem_en;
    logic         mem_rd_wr;
    logic [15:0]  mem_address;
    logic [63:0]  mem_rdata;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;

    modport master (
        output mem_en, mem_rd_wr, mem_address, blk_data, blk_valid,
        input  mem_rdata, blk_ready
    );

    modport slave (
        input  mem_en, mem_rd_wr, mem_address, blk_data, blk_valid,
        output mem_rdata, blk_ready
    );
endinterface

// File: rtl/mem_block_fetch.sv
// Reads 8 consecutive 64-bit words per block from a registered-read memory and
// presents each group as one 512-bit block (word 0 in the MSBs) over valid/ready.
module mem_block_fetch #(
    parameter int WORDS_PER_BLK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       base_addr,
    input  logic [7:0]        num_blocks,
    output logic              busy,
    output logic              done,
    mem_block_fetch_if.master bus
);
    localparam int WCW = $clog2(WORDS_PER_BLK);

    typedef enum logic [1:0] {IDLE, READ, CAP, HOLD} state_t;

    state_t                              state_q, state_d;
    logic [15:0]                         addr_cnt;
    logic [7:0]                          remain;
    logic [WCW-1:0]                      word_cnt;
    logic [WCW-1:0]                      cap_slot;
    logic                                cap_en;
    logic [WORDS_PER_BLK-1:0][63:0]      blk_q;
    logic                                blk_valid_q;
    logic                                accept, zero_cmd, handshake, last_blk;

    assign bus.mem_en      = (state_q == READ);
    assign bus.mem_rd_wr   = 1'b0;
    assign bus.mem_address = addr_cnt;
    assign bus.blk_data    = blk_q;
    assign bus.blk_valid   = blk_valid_q;

    // Read data lags the address by one cycle, so the slot being filled is
    // word_cnt-1; in CAP word_cnt has wrapped to 0, which lands on the last slot.
    assign cap_slot = word_cnt - 1'b1;
    assign cap_en   = ((state_q == READ) && (word_cnt != '0)) || (state_q == CAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        zero_cmd  = 1'b0;
        handshake = 1'b0;
        last_blk  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_blocks != 8'd0) begin
                        accept  = 1'b1;
                        state_d = READ;
                    end else begin
                        zero_cmd = 1'b1;
                    end
                end
            end
            READ: begin
                if (word_cnt == WCW'(WORDS_PER_BLK - 1)) state_d = CAP;
            end
            CAP: state_d = HOLD;
            HOLD: begin
                if (blk_valid_q && bus.blk_ready) begin
                    handshake = 1'b1;
                    last_blk  = (remain == 8'd1);
                    state_d   = last_blk ? IDLE : READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt    <= '0;
            remain      <= '0;
            word_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_q       <= '0;
        end else begin
            done <= zero_cmd | (handshake & last_blk);

            if (accept) begin
                addr_cnt <= base_addr;
                remain   <= num_blocks;
                word_cnt <= '0;
                busy     <= 1'b1;
            end

            // addr_cnt is never reloaded between blocks: block b starts at base+8b.
            if (state_q == READ) begin
                addr_cnt <= addr_cnt + 16'd1;
                word_cnt <= word_cnt + 1'b1;
            end

            if (state_q == CAP) blk_valid_q <= 1'b1;

            if (handshake) begin
                blk_valid_q <= 1'b0;
                remain      <= remain - 8'd1;
                word_cnt    <= '0;
                if (last_blk) busy <= 1'b0;
            end

            for (int k = 0; k < WORDS_PER_BLK; k++) begin
                if (cap_en && (cap_slot == WCW'(k)))
                    blk_q[WORDS_PER_BLK-1-k] <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_block_fetch.sv
// Directed bench for mem_block_fetch with a registered-read 64K x 64 memory model.
module tb_mem_block_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  num_blocks;
    logic        busy, done;
    logic [63:0] mem [0:65535];
    int          n_cmp = 0;
    int          n_err = 0;

    mem_block_fetch_if bus();

    mem_block_fetch dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_blocks(num_blocks), .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_address];

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; base_addr = '0; num_blocks = '0; bus.blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got=%0b exp=0", bus.mem_en); end
        n_cmp++; if (bus.mem_rd_wr !== 1'b0) begin n_err++; $display("FAIL reset_rd_wr got=%0b exp=0", bus.mem_rd_wr); end
        n_cmp++; if (bus.mem_address !== 16'h0000) begin n_err++; $display("FAIL reset_addr got=%h exp=0000", bus.mem_address); end
        n_cmp++; if (bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.blk_valid); end
        n_cmp++; if (bus.blk_data !== 512'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bus.blk_data); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_release busy=%0b mem_en=%0b exp=0,0", busy, bus.mem_en); end
    endtask

    task automatic test_single();
        logic [511:0] exp;
        logic [15:0]  a;
        for (int k = 0; k < 8; k++) begin
            a = 16'h0100 + 16'(k);
            mem[a] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        end
        exp = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
               64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
        bus.blk_ready = 1'b1; base_addr = 16'h0100; num_blocks = 8'd1; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            a = 16'h0100 + 16'(j);
            n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_address !== a || busy !== 1'b1 || bus.mem_rd_wr !== 1'b0) begin
                n_err++; $display("FAIL single_read%0d en=%0b addr=%h busy=%0b rw=%0b exp 1,%h,1,0", j, bus.mem_en, bus.mem_address, busy, bus.mem_rd_wr, a);
            end
            @(negedge clk);
        end
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL single_cap en=%0b valid=%0b exp 0,0", bus.mem_en, bus.blk_valid); end
        @(negedge clk);
        n_cmp++; if (bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_e9 got=%0b exp=1", bus.blk_valid); end
        n_cmp++; if (bus.blk_data !== exp) begin n_err++; $display("FAIL single_data got=%h exp=%h", bus.blk_data, exp); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL single_done done=%0b busy=%0b valid=%0b exp 1,0,0", done, busy, bus.blk_valid); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_width got=%0b exp=0", done); end
        n_cmp++; if (bus.blk_data !== exp) begin n_err++; $display("FAIL single_data_kept got=%h exp=%h", bus.blk_data, exp); end
        bus.blk_ready = 1'b0;
    endtask

    task automatic test_multi_backpressure();
        logic [511:0] exp;
        logic [15:0]  a;
        logic         got;
        int           n_done = 0;
        for (int i = 0; i < 24; i++) begin
            a = 16'h0200 + 16'(i);
            mem[a] = {16'hC0DE, 16'(i), 16'h5A5A, ~16'(i)};
        end
        bus.blk_ready = 1'b0; base_addr = 16'h0200; num_blocks = 8'd3; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 8; k++) exp[511-64*k -: 64] = {16'hC0DE, 16'(8*b+k), 16'h5A5A, ~16'(8*b+k)};
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                if (done) n_done++;
                @(negedge clk);
                if (bus.blk_valid) got = 1'b1;
            end
            n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL multi_wait%0d valid never rose exp=1", b); end
            n_cmp++; if (bus.blk_data !== exp) begin n_err++; $display("FAIL multi_data%0d got=%h exp=%h", b, bus.blk_data, exp); end
            for (int h = 0; h < 5; h++) begin
                @(negedge clk);
                n_cmp++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp || done !== 1'b0) begin
                    n_err++; $display("FAIL multi_hold%0d_%0d valid=%0b done=%0b data=%h exp 1,0,%h", b, h, bus.blk_valid, done, bus.blk_data, exp);
                end
            end
            bus.blk_ready = 1'b1;
            @(negedge clk);
            bus.blk_ready = 1'b0;
            if (done) n_done++;
            n_cmp++; if (bus.blk_valid !== 1'b0 || done !== (b == 2)) begin
                n_err++; $display("FAIL multi_hs%0d valid=%0b done=%0b exp 0,%0b", b, bus.blk_valid, done, (b == 2));
            end
        end
        @(negedge clk);
        if (done) n_done++;
        n_cmp++; if (n_done !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL multi_done_count got=%0d busy=%0b exp 1,0", n_done, busy); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] vpat, dpat;
        bus.blk_ready = 1'b1; base_addr = 16'h0200; num_blocks = 8'd2; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        vpat = '0; dpat = '0;
        for (int j = 0; j < 22; j++) begin
            vpat[j] = bus.blk_valid;
            dpat[j] = done;
            if (j == 19) begin
                n_cmp++; if (bus.blk_data[511:448] !== {16'hC0DE, 16'd8, 16'h5A5A, ~16'd8}) begin
                    n_err++; $display("FAIL b2b_data got=%h exp word 0x208", bus.blk_data[511:448]);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (vpat !== 22'h08_0200) begin n_err++; $display("FAIL b2b_valid_timing got=%h exp=080200", vpat); end
        n_cmp++; if (dpat !== 22'h10_0000) begin n_err++; $display("FAIL b2b_done_timing got=%h exp=100000", dpat); end
        bus.blk_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [511:0] exp;
        logic [15:0]  a;
        for (int k = 0; k < 8; k++) begin
            a = 16'hFFFC + 16'(k);
            mem[a] = {48'hAB_CDEF_0000, a};
            exp[511-64*k -: 64] = {48'hAB_CDEF_0000, a};
        end
        bus.blk_ready = 1'b1; base_addr = 16'hFFFC; num_blocks = 8'd1; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            a = 16'hFFFC + 16'(j);
            n_cmp++; if (bus.mem_address !== a || bus.mem_en !== 1'b1) begin n_err++; $display("FAIL wrap_addr%0d got=%h en=%0b exp=%h,1", j, bus.mem_address, bus.mem_en, a); end
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp) begin n_err++; $display("FAIL wrap_data valid=%0b got=%h exp=%h", bus.blk_valid, bus.blk_data, exp); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%0b exp=1", done); end
        bus.blk_ready = 1'b0;
    endtask

    task automatic test_zero_and_ignored();
        logic [511:0] exp0, exp1;
        logic [15:0]  a;
        logic         got;
        base_addr = 16'h0300; num_blocks = 8'd0; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || bus.mem_en !== 1'b0) begin n_err++; $display("FAIL zero_done done=%0b busy=%0b en=%0b exp 1,0,0", done, busy, bus.mem_en); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || bus.mem_en !== 1'b0) begin n_err++; $display("FAIL zero_after done=%0b en=%0b exp 0,0", done, bus.mem_en); end

        for (int i = 0; i < 16; i++) begin
            a = 16'h0300 + 16'(i);
            mem[a] = {32'hFACE_0000 + 32'(i), 32'h1234_5678};
            if (i < 8) exp0[511-64*i -: 64] = {32'hFACE_0000 + 32'(i), 32'h1234_5678};
            else       exp1[511-64*(i-8) -: 64] = {32'hFACE_0000 + 32'(i), 32'h1234_5678};
        end
        a = 16'h0500;
        mem[a] = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.blk_ready = 1'b0; base_addr = 16'h0300; num_blocks = 8'd2; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); if (bus.blk_valid) got = 1'b1; end
        n_cmp++; if (got !== 1'b1 || bus.blk_data !== exp0) begin n_err++; $display("FAIL ign_blk0 valid=%0b got=%h exp=%h", got, bus.blk_data, exp0); end
        base_addr = 16'h0500; num_blocks = 8'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (bus.blk_valid !== 1'b1 || busy !== 1'b1 || bus.blk_data !== exp0) begin n_err++; $display("FAIL ign_hold valid=%0b busy=%0b data=%h exp 1,1,%h", bus.blk_valid, busy, bus.blk_data, exp0); end
        bus.blk_ready = 1'b1; @(negedge clk); bus.blk_ready = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); if (bus.blk_valid) got = 1'b1; end
        n_cmp++; if (got !== 1'b1 || bus.blk_data !== exp1) begin n_err++; $display("FAIL ign_blk1 valid=%0b got=%h exp=%h", got, bus.blk_data, exp1); end
        bus.blk_ready = 1'b1; @(negedge clk); bus.blk_ready = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ign_done done=%0b busy=%0b exp 1,0", done, busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || bus.mem_en !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ign_idle busy=%0b en=%0b done=%0b exp 0,0,0", busy, bus.mem_en, done); end
    endtask

    task automatic test_async_reset();
        logic [511:0] exp;
        logic         got;
        for (int k = 0; k < 8; k++) exp[511-64*k -: 64] = {16'hC0DE, 16'(k), 16'h5A5A, ~16'(k)};
        bus.blk_ready = 1'b1; base_addr = 16'h0100; num_blocks = 8'd1; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL arst_outputs busy=%0b en=%0b valid=%0b exp 0,0,0", busy, bus.mem_en, bus.blk_valid); end
        n_cmp++; if (bus.blk_data !== 512'd0 || bus.mem_address !== 16'h0000) begin n_err++; $display("FAIL arst_data addr=%h data=%h exp 0000,0", bus.mem_address, bus.blk_data); end
        @(negedge clk); rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL arst_idle%0d busy=%0b en=%0b valid=%0b exp 0,0,0", j, busy, bus.mem_en, bus.blk_valid); end
        end
        base_addr = 16'h0200; num_blocks = 8'd1; start = 1'b1; bus.blk_ready = 1'b0;
        @(posedge clk); @(negedge clk); start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); if (bus.blk_valid) got = 1'b1; end
        n_cmp++; if (got !== 1'b1 || bus.blk_data !== exp) begin n_err++; $display("FAIL arst_refetch valid=%0b got=%h exp=%h", got, bus.blk_data, exp); end
        bus.blk_ready = 1'b1; @(negedge clk); bus.blk_ready = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL arst_done done=%0b busy=%0b exp 1,0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_backpressure();
        test_back_to_back();
        test_wrap();
        test_zero_and_ignored();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
